// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the pmem arbiter: line type, arbiter state and latched command.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package pmem_arbiter_pkg;

    // One cache line as seen on every pmem data bus.
    typedef logic [127:0] lc3b_pmem_line;

    // Arbiter state: idle (arbitrating) or owned by one of the caches.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2
    } arb_state_t;

    // Command latched at the grant edge; the memory strobes decode from it.
    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } pmem_cmd_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one pmem line port between I-cache and D-cache misses; D favoured, I starvation bounded.
// Latency: request seen in IDLE -> registered pmem strobe next cycle; resp routed combinationally.
// Backpressure: strobes held until pmem_resp; each cache holds its request until its own *_resp.
//
// Ports:
//   clk, reset                         clock, synchronous active-low reset
//   i_pmem_read/address, i_pmem_resp/rdata               I-cache line read port
//   d_pmem_read/write/address/wdata, d_pmem_resp/rdata   D-cache read/writeback port
//   pmem_read/write/address/wdata, pmem_resp/rdata       main-memory line port
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = $bits(lc3b_pmem_line),
    parameter int MAX_D_BURST = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic              i_pmem_resp,
    output logic [LINE_W-1:0] i_pmem_rdata,

    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic              d_pmem_resp,
    output logic [LINE_W-1:0] d_pmem_rdata,

    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata
);

    localparam int               CNT_W     = $clog2(MAX_D_BURST + 1);
    localparam logic [CNT_W-1:0] D_CNT_MAX = CNT_W'(MAX_D_BURST);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [CNT_W-1:0]  d_cnt;
    pmem_cmd_t         cmd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;

    logic i_req;
    logic d_req;
    logic grant_i;
    logic grant_d;
    logic done;

    // Next-state and grant decisions. Grants are only made in IDLE, which
    // guarantees one dead cycle between consecutive memory transactions.
    always_comb begin
        i_req   = i_pmem_read;
        d_req   = d_pmem_read | d_pmem_write;
        grant_i = 1'b0;
        grant_d = 1'b0;
        done    = 1'b0;
        state_d = state_q;

        case (state_q)
            ARB_IDLE: begin
                if (i_req && d_req) begin
                    // D wins unless it has already taken its burst allowance
                    // while I was waiting.
                    if (d_cnt == D_CNT_MAX) begin
                        grant_i = 1'b1;
                    end else begin
                        grant_d = 1'b1;
                    end
                end else if (i_req) begin
                    grant_i = 1'b1;
                end else if (d_req) begin
                    grant_d = 1'b1;
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if (pmem_resp) begin
                    done    = 1'b1;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (grant_i) begin
            state_d = ARB_I_BUSY;
        end else if (grant_d) begin
            state_d = ARB_D_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ARB_IDLE;
            d_cnt   <= '0;
            cmd_q   <= CMD_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;

            // Transaction latch: loaded at the grant edge, cleared on
            // completion so the memory port reads all-zero whenever idle.
            if (grant_i) begin
                cmd_q   <= CMD_READ;
                addr_q  <= i_pmem_address;
                wdata_q <= '0;
            end else if (grant_d) begin
                // A simultaneous read+write is illegal; the write is taken.
                cmd_q   <= d_pmem_write ? CMD_WRITE : CMD_READ;
                addr_q  <= d_pmem_address;
                wdata_q <= d_pmem_write ? d_pmem_wdata : '0;
            end else if (done) begin
                cmd_q   <= CMD_NONE;
                addr_q  <= '0;
                wdata_q <= '0;
            end

            // Starvation counter: counts D grants that overtook a waiting I.
            if (grant_d && i_req) begin
                if (d_cnt != D_CNT_MAX) begin
                    d_cnt <= d_cnt + CNT_W'(1);
                end
            end else if (grant_i || grant_d) begin
                d_cnt <= '0;
            end
        end
    end

    // Memory port comes straight from the latch; no cache input reaches it
    // combinationally.
    assign pmem_read    = (cmd_q == CMD_READ);
    assign pmem_write   = (cmd_q == CMD_WRITE);
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Completion goes only to the owner; a stray resp in IDLE is dropped.
    assign i_pmem_resp  = (state_q == ARB_I_BUSY) && pmem_resp;
    assign d_pmem_resp  = (state_q == ARB_D_BUSY) && pmem_resp;

    // Read data is shared; only *_resp qualifies it.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    illegal_d_read_write: assert property (
        @(posedge clk) disable iff (!reset) !(d_pmem_read && d_pmem_write)
    );

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

    localparam int ADDR_W      = 16;
    localparam int LINE_W      = 128;
    localparam int MAX_D_BURST = 2;

    localparam logic [LINE_W-1:0] BEEF_LINE = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [LINE_W-1:0] A5_LINE   = {16{8'hA5}};

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              i_pmem_read = 1'b0;
    logic [ADDR_W-1:0] i_pmem_address = '0;
    logic              i_pmem_resp;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              d_pmem_read = 1'b0;
    logic              d_pmem_write = 1'b0;
    logic [ADDR_W-1:0] d_pmem_address = '0;
    logic [LINE_W-1:0] d_pmem_wdata = '0;
    logic              d_pmem_resp;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic              pmem_resp = 1'b0;
    logic [LINE_W-1:0] pmem_rdata = '0;

    int vec_cnt = 0;
    int err_cnt = 0;

    pmem_arbiter #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .MAX_D_BURST (MAX_D_BURST)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_resp    (i_pmem_resp),
        .i_pmem_rdata   (i_pmem_rdata),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_resp    (d_pmem_resp),
        .d_pmem_rdata   (d_pmem_rdata),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_resp      (pmem_resp),
        .pmem_rdata     (pmem_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled
    // on the falling edge.
    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_resp      = 1'b0;
        pmem_rdata     = '0;
    endtask

    // Leaves the bench at the start of an IDLE cycle ("cycle 0").
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset          = 1'b0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1111;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h2222;
        for (int c = 0; c < 2; c++) begin
            next_cyc();
            settle();
            vec_cnt++;
            if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
                err_cnt++;
                $display("FAIL rst_strobes cyc%0d: got %b want 0000", c,
                         {pmem_read, pmem_write, i_pmem_resp, d_pmem_resp});
            end
            vec_cnt++;
            if (pmem_address !== 16'h0000 || pmem_wdata !== '0) begin
                err_cnt++;
                $display("FAIL rst_addr cyc%0d: got %h want 0000", c, pmem_address);
            end
        end
        next_cyc();
        reset = 1'b1;
        next_cyc();
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h2222) begin
            err_cnt++;
            $display("FAIL rst_first_grant: got rd=%b addr=%h want rd=1 addr=2222",
                     pmem_read, pmem_address);
        end
    endtask

    task automatic test_i_read();
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h1230;
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL iread_cyc0_strobe: got %b want 0", pmem_read);
        end
        next_cyc();
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 16'h1230) begin
            err_cnt++;
            $display("FAIL iread_cyc1: got rd=%b wr=%b addr=%h want rd=1 wr=0 addr=1230",
                     pmem_read, pmem_write, pmem_address);
        end
        next_cyc();
        next_cyc();
        next_cyc();
        settle();
        vec_cnt++;
        if (i_pmem_resp !== 1'b0 || pmem_read !== 1'b1) begin
            err_cnt++;
            $display("FAIL iread_cyc4_hold: got resp=%b rd=%b want resp=0 rd=1",
                     i_pmem_resp, pmem_read);
        end
        next_cyc();
        pmem_resp  = 1'b1;
        pmem_rdata = BEEF_LINE;
        settle();
        vec_cnt++;
        if (i_pmem_resp !== 1'b1 || d_pmem_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL iread_cyc5_resp: got i=%b d=%b want i=1 d=0", i_pmem_resp, d_pmem_resp);
        end
        vec_cnt++;
        if (i_pmem_rdata !== BEEF_LINE || d_pmem_rdata !== BEEF_LINE) begin
            err_cnt++;
            $display("FAIL iread_rdata: got i=%h d=%h want %h", i_pmem_rdata, d_pmem_rdata, BEEF_LINE);
        end
        next_cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b0 || i_pmem_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL iread_cyc6_drop: got rd=%b resp=%b want 0 0", pmem_read, i_pmem_resp);
        end
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0040;
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h8000;
        d_pmem_wdata   = A5_LINE;
        next_cyc();
        settle();
        vec_cnt++;
        if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 16'h8000) begin
            err_cnt++;
            $display("FAIL both_d_first: got wr=%b rd=%b addr=%h want wr=1 rd=0 addr=8000",
                     pmem_write, pmem_read, pmem_address);
        end
        vec_cnt++;
        if (pmem_wdata !== A5_LINE) begin
            err_cnt++;
            $display("FAIL both_wdata: got %h want %h", pmem_wdata, A5_LINE);
        end
        next_cyc();
        next_cyc();
        pmem_resp = 1'b1;
        settle();
        vec_cnt++;
        if (d_pmem_resp !== 1'b1 || i_pmem_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL both_d_resp: got d=%b i=%b want d=1 i=0", d_pmem_resp, i_pmem_resp);
        end
        next_cyc();
        pmem_resp    = 1'b0;
        d_pmem_write = 1'b0;
        settle();
        vec_cnt++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL both_idle_gap: got wr=%b rd=%b want 0 0", pmem_write, pmem_read);
        end
        next_cyc();
        pmem_resp = 1'b1;
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0040 || i_pmem_resp !== 1'b1) begin
            err_cnt++;
            $display("FAIL both_i_second: got rd=%b addr=%h iresp=%b want rd=1 addr=0040 iresp=1",
                     pmem_read, pmem_address, i_pmem_resp);
        end
        next_cyc();
        pmem_resp   = 1'b0;
        i_pmem_read = 1'b0;
    endtask

    task automatic test_starvation_burst();
        logic [ADDR_W-1:0] exp_addr [6];
        exp_addr = '{16'h0200, 16'h0200, 16'h0100, 16'h0200, 16'h0200, 16'h0100};
        do_reset();
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0100;
        d_pmem_read    = 1'b1;
        d_pmem_address = 16'h0200;
        for (int g = 0; g < 6; g++) begin
            next_cyc();
            pmem_resp = 1'b1;
            settle();
            vec_cnt++;
            if (pmem_read !== 1'b1 || pmem_address !== exp_addr[g]) begin
                err_cnt++;
                $display("FAIL burst_grant%0d: got rd=%b addr=%h want rd=1 addr=%h",
                         g, pmem_read, pmem_address, exp_addr[g]);
            end
            vec_cnt++;
            if ({i_pmem_resp, d_pmem_resp} !== ((exp_addr[g] == 16'h0100) ? 2'b10 : 2'b01)) begin
                err_cnt++;
                $display("FAIL burst_resp%0d: got i/d=%b%b want owner only",
                         g, i_pmem_resp, d_pmem_resp);
            end
            next_cyc();
            pmem_resp = 1'b0;
            settle();
            vec_cnt++;
            if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
                err_cnt++;
                $display("FAIL burst_gap%0d: got rd=%b wr=%b want 0 0", g, pmem_read, pmem_write);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_txn();
        do_reset();
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h8000;
        d_pmem_wdata   = A5_LINE;
        next_cyc();
        next_cyc();
        next_cyc();
        reset        = 1'b0;
        d_pmem_write = 1'b0;
        settle();
        vec_cnt++;
        if (pmem_write !== 1'b1) begin
            err_cnt++;
            $display("FAIL rmid_busy_cyc3: got wr=%b want 1", pmem_write);
        end
        next_cyc();
        reset = 1'b1;
        settle();
        vec_cnt++;
        if (pmem_write !== 1'b0 || pmem_address !== 16'h0000) begin
            err_cnt++;
            $display("FAIL rmid_drop: got wr=%b addr=%h want wr=0 addr=0000", pmem_write, pmem_address);
        end
        next_cyc();
        pmem_resp = 1'b1;
        settle();
        vec_cnt++;
        if (d_pmem_resp !== 1'b0 || i_pmem_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL rmid_late_resp: got d=%b i=%b want 0 0", d_pmem_resp, i_pmem_resp);
        end
        next_cyc();
        pmem_resp = 1'b0;
        settle();
        vec_cnt++;
        if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
            err_cnt++;
            $display("FAIL rmid_stay_idle: got wr=%b rd=%b want 0 0", pmem_write, pmem_read);
        end
    endtask

    task automatic test_idle_resp();
        do_reset();
        pmem_resp  = 1'b1;
        pmem_rdata = BEEF_LINE;
        settle();
        vec_cnt++;
        if (i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0) begin
            err_cnt++;
            $display("FAIL idle_resp: got i=%b d=%b want 0 0", i_pmem_resp, d_pmem_resp);
        end
        next_cyc();
        pmem_resp      = 1'b0;
        i_pmem_read    = 1'b1;
        i_pmem_address = 16'h0ABC;
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b0 || pmem_address !== 16'h0000) begin
            err_cnt++;
            $display("FAIL idle_resp_state: got rd=%b addr=%h want rd=0 addr=0000",
                     pmem_read, pmem_address);
        end
        next_cyc();
        settle();
        vec_cnt++;
        if (pmem_read !== 1'b1 || pmem_address !== 16'h0ABC) begin
            err_cnt++;
            $display("FAIL idle_resp_then_grant: got rd=%b addr=%h want rd=1 addr=0abc",
                     pmem_read, pmem_address);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_both_same_cycle();
        test_starvation_burst();
        test_reset_mid_txn();
        test_idle_resp();
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
